// File: rtl/mrtnt_input_pkg.sv
// Shared types and constants for the Mr.TNT input sequencing logic.
package mrtnt_input_pkg;

   // Width of the per-state frame down-counter (durations 1..15 frames).
   localparam int FRAME_W   = 4;
   // Largest number of coins an automatic sequence inserts (2P start).
   localparam int MAX_COINS = 2;
   localparam int COIN_W    = $clog2(MAX_COINS + 1);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_COIN    = 3'd1,
      ST_GAP     = 3'd2,
      ST_START   = 3'd3,
      ST_RELEASE = 3'd4,
      ST_MANUAL  = 3'd5
   } seq_state_t;

   typedef enum logic {
      P1 = 1'b0,
      P2 = 1'b1
   } player_t;

endpackage

// File: rtl/frame_timer.sv
// VBLANK rising-edge detector plus a loadable frame down-counter.
// tick is one cycle wide per frame; done flags that the current tick
// is the last one of the loaded duration (count at 1).
module frame_timer
   import mrtnt_input_pkg::*;
(
   input  logic               clk_sys,
   input  logic               srst,
   input  logic               vblank,
   input  logic               load,
   input  logic [FRAME_W-1:0] load_val,
   output logic               tick,
   output logic               done
);

   logic               vblank_q_reg;
   logic [FRAME_W-1:0] cnt_reg;

   assign tick = vblank & ~vblank_q_reg;
   assign done = (cnt_reg == FRAME_W'(1));

   // Delay VBLANK one cycle for edge detection; load or count down per tick.
   always_ff @(posedge clk_sys) begin
      if (srst) begin
         vblank_q_reg <= 1'b0;
         cnt_reg      <= '0;
      end else begin
         vblank_q_reg <= vblank;
         if (load) begin
            cnt_reg <= load_val;
         end else if (tick && (cnt_reg != '0)) begin
            cnt_reg <= cnt_reg - FRAME_W'(1);
         end
      end
   end

endmodule

// File: rtl/coin_start_seq.sv
// Turns a Start request into coin pulse(s), a gap and a Start pulse, all
// timed in whole frames (VBLANK rising edges); also arbitrates a manual
// coin onto the same coin line.
// Optional build macro: COIN_START_SEQ_WATCHDOG_EN aborts a sequence to
// RELEASE when no frame tick arrives for TIMEOUT_CLKS cycles.
module coin_start_seq
   import mrtnt_input_pkg::*;
#(
   parameter int COIN_FRAMES  = 3,
   parameter int GAP_FRAMES   = 6,
   parameter int START_FRAMES = 3,
   parameter int TIMEOUT_CLKS = 2000000
)(
   input  logic CLK,
   input  logic RESET,
   input  logic VBLANK,
   input  logic req_start1,
   input  logic req_start2,
   input  logic req_coin,
   output logic coin_o,
   output logic start1_o,
   output logic start2_o,
   output logic busy
);

   // Durations must fit the frame counter and be non-zero.
   if (COIN_FRAMES < 1 || COIN_FRAMES >= (1 << FRAME_W) ||
       GAP_FRAMES < 1 || GAP_FRAMES >= (1 << FRAME_W) ||
       START_FRAMES < 1 || START_FRAMES >= (1 << FRAME_W) ||
       TIMEOUT_CLKS < 1) begin : g_param_check
      $error("coin_start_seq: parameter out of range");
   end

   seq_state_t         state_reg, state_next;
   player_t            player_reg, player_next;
   logic [COIN_W-1:0]  coins_reg, coins_next;
   logic               min_met_reg;
   logic               coin_reg, start1_reg, start2_reg, busy_reg;
   logic               tmr_load;
   logic [FRAME_W-1:0] tmr_val;
   logic               tick;
   logic               tmr_done;
   logic               last_tick;
   logic               any_req;
   logic               wd_timeout;

   frame_timer u_frame_timer (
      .clk_sys  (CLK),
      .srst     (RESET),
      .vblank   (VBLANK),
      .load     (tmr_load),
      .load_val (tmr_val),
      .tick     (tick),
      .done     (tmr_done)
   );

   assign last_tick = tick & tmr_done;
   assign any_req   = req_start1 | req_start2 | req_coin;

`ifdef COIN_START_SEQ_WATCHDOG_EN
   localparam int WD_W = $clog2(TIMEOUT_CLKS + 1);
   logic [WD_W-1:0] wd_cnt_reg;

   assign wd_timeout = (wd_cnt_reg == WD_W'(TIMEOUT_CLKS - 1)) &&
                       (state_reg != ST_IDLE) && !tick;

   // Count cycles since the last frame tick; saturate once timed out.
   always_ff @(posedge CLK) begin
      if (RESET || (state_reg == ST_IDLE) || tick) begin
         wd_cnt_reg <= '0;
      end else if (!wd_timeout) begin
         wd_cnt_reg <= wd_cnt_reg + WD_W'(1);
      end
   end
`else
   assign wd_timeout = 1'b0;
`endif

   // Next-state logic; the frame timer is loaded on every timed-state entry.
   always_comb begin
      state_next  = state_reg;
      player_next = player_reg;
      coins_next  = coins_reg;
      tmr_load    = 1'b0;
      tmr_val     = '0;
      case (state_reg)
         ST_IDLE: begin
            if (req_start1 || req_start2) begin
               player_next = req_start1 ? P1 : P2;
               coins_next  = req_start1 ? COIN_W'(1) : COIN_W'(MAX_COINS);
               state_next  = ST_COIN;
               tmr_load    = 1'b1;
               tmr_val     = FRAME_W'(COIN_FRAMES);
            end else if (req_coin) begin
               state_next = ST_MANUAL;
               tmr_load   = 1'b1;
               tmr_val    = FRAME_W'(COIN_FRAMES);
            end
         end
         ST_COIN: begin
            if (last_tick) begin
               coins_next = coins_reg - COIN_W'(1);
               state_next = ST_GAP;
               tmr_load   = 1'b1;
               tmr_val    = FRAME_W'(GAP_FRAMES);
            end
         end
         ST_GAP: begin
            if (last_tick) begin
               tmr_load = 1'b1;
               if (coins_reg != '0) begin
                  state_next = ST_COIN;
                  tmr_val    = FRAME_W'(COIN_FRAMES);
               end else begin
                  state_next = ST_START;
                  tmr_val    = FRAME_W'(START_FRAMES);
               end
            end
         end
         ST_START: begin
            if (last_tick) begin
               state_next = ST_RELEASE;
            end
         end
         ST_RELEASE: begin
            if (!any_req) begin
               state_next = ST_IDLE;
            end
         end
         ST_MANUAL: begin
            if (!req_coin && (min_met_reg || last_tick)) begin
               state_next = ST_RELEASE;
            end
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
      if (wd_timeout && (state_reg != ST_RELEASE)) begin
         state_next = ST_RELEASE;
      end
   end

   // State and registered outputs, derived from the state being entered.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_reg  <= ST_IDLE;
         player_reg <= P1;
         coins_reg  <= '0;
         coin_reg   <= 1'b0;
         start1_reg <= 1'b0;
         start2_reg <= 1'b0;
         busy_reg   <= 1'b0;
      end else begin
         state_reg  <= state_next;
         player_reg <= player_next;
         coins_reg  <= coins_next;
         coin_reg   <= (state_next == ST_COIN) || (state_next == ST_MANUAL);
         start1_reg <= (state_next == ST_START) && (player_next == P1);
         start2_reg <= (state_next == ST_START) && (player_next == P2);
         busy_reg   <= (state_next != ST_IDLE);
      end
   end

   // Remember that the manual coin has been held for its minimum length.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         min_met_reg <= 1'b0;
      end else begin
         min_met_reg <= (state_reg == ST_MANUAL) && (min_met_reg || last_tick);
      end
   end

   assign coin_o   = coin_reg;
   assign start1_o = start1_reg;
   assign start2_o = start2_reg;
   assign busy     = busy_reg;

endmodule

// File: tb/tb_coin_start_seq.sv
// Self-checking bench for coin_start_seq. Outputs are sampled once per
// frame mid-way between frame ticks and compared against a frame-level
// timeline computed from the sequence durations.
module tb_coin_start_seq;

   localparam int C   = 3;
   localparam int G   = 6;
   localparam int S   = 3;
   localparam int TMO = 500;

   logic clk = 1'b0;
   logic RESET, VBLANK, req_start1, req_start2, req_coin;
   logic coin_o, start1_o, start2_o, busy;

   int period   = 100;
   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   coin_start_seq #(
      .COIN_FRAMES  (C),
      .GAP_FRAMES   (G),
      .START_FRAMES (S),
      .TIMEOUT_CLKS (TMO)
   ) dut (
      .CLK        (clk),
      .RESET      (RESET),
      .VBLANK     (VBLANK),
      .req_start1 (req_start1),
      .req_start2 (req_start2),
      .req_coin   (req_coin),
      .coin_o     (coin_o),
      .start1_o   (start1_o),
      .start2_o   (start2_o),
      .busy       (busy)
   );

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // One frame: VBLANK high for the first 8 cycles, request levels applied
   // at cycle 20, optional glitches at 30, sample at 50.
   task automatic run_frame(input logic s1, input logic s2, input logic c,
                            input bit pulse, input bit noise, input bit rst_pulse,
                            output logic [3:0] smp, output logic [3:0] rs,
                            output bit excl_bad);
      smp = '0;
      rs = '0;
      excl_bad = 1'b0;
      for (int i = 0; i < period; i++) begin
         VBLANK = (i < 8);
         if (i == 20) begin
            req_start1 = s1; req_start2 = s2; req_coin = c;
         end
         if (i == 21 && pulse) begin
            req_start1 = 1'b0; req_start2 = 1'b0; req_coin = 1'b0;
         end
         if (i == 30 && noise) begin
            req_start1 = 1'b1; req_start2 = 1'b1; req_coin = 1'b1;
         end
         if (i == 31 && noise) begin
            req_start1 = s1 && !pulse; req_start2 = s2 && !pulse; req_coin = c && !pulse;
         end
         if (i == 30 && rst_pulse) RESET = 1'b1;
         if (i == 31 && rst_pulse) begin
            rs = {busy, start2_o, start1_o, coin_o};
            RESET = 1'b0;
         end
         if (i == 50) smp = {busy, start2_o, start1_o, coin_o};
         if ((32'(coin_o) + 32'(start1_o) + 32'(start2_o)) > 1) excl_bad = 1'b1;
         cyc();
      end
   endtask

   // Automatic sequence: request raised in frame 0, held for 'hold' frames
   // (0 = single-cycle pulse).
   task automatic run_auto(input logic s1, input logic s2, input int hold,
                           input bit noisy, input string tag);
      logic [3:0] smp, rs, exp;
      bit xb, lv, nz, p1;
      int n, len, total;
      p1 = s1;
      n = s1 ? 1 : 2;
      len = n * (C + G) + S;
      total = ((hold > len) ? hold : len) + 2;
      for (int k = 0; k < total; k++) begin
         lv = (k < hold) || (hold == 0 && k == 0);
         nz = noisy && (k >= 1) && (k <= len - 2) && ($urandom_range(0, 1) == 1);
         run_frame(s1 && lv, s2 && lv, 1'b0, (hold == 0 && k == 0), nz, 1'b0, smp, rs, xb);
         exp = '0;
         if (k < len) begin
            exp[3] = 1'b1;
            if (k < n * (C + G)) exp[0] = ((k % (C + G)) < C);
            else if (p1) exp[1] = 1'b1;
            else exp[2] = 1'b1;
         end else begin
            exp[3] = (k < hold);
         end
         n_checks++;
         if (smp !== exp)
            $display("FAIL %s frame %0d: {busy,start2,start1,coin}=%b required %b", tag, k, smp, exp);
         else n_pass++;
         n_checks++;
         if (xb !== 1'b0)
            $display("FAIL %s frame %0d exclusive: overlap=%b required 0", tag, k, xb);
         else n_pass++;
      end
   endtask

   // Manual coin held for h frames (0 = single-cycle pulse).
   task automatic run_manual(input int h, input bit noisy, input string tag);
      logic [3:0] smp, rs, exp;
      bit xb, lv, nz;
      int m;
      m = (h > C) ? h : C;
      for (int k = 0; k < m + 2; k++) begin
         lv = (k < h) || (h == 0 && k == 0);
         nz = noisy && (k >= 1) && (k <= m - 2) && ($urandom_range(0, 1) == 1);
         run_frame(1'b0, 1'b0, lv, (h == 0 && k == 0), nz, 1'b0, smp, rs, xb);
         exp = (k < m) ? 4'b1001 : 4'b0000;
         n_checks++;
         if (smp !== exp)
            $display("FAIL %s frame %0d: {busy,start2,start1,coin}=%b required %b", tag, k, smp, exp);
         else n_pass++;
         n_checks++;
         if (xb !== 1'b0)
            $display("FAIL %s frame %0d exclusive: overlap=%b required 0", tag, k, xb);
         else n_pass++;
      end
   endtask

   task automatic test_reset();
      logic [3:0] smp, rs;
      bit xb;
      RESET = 1'b1;
      req_start1 = 1'b1; req_start2 = 1'b0; req_coin = 1'b1;
      VBLANK = 1'b1;
      for (int i = 0; i < 4; i++) begin
         cyc();
         n_checks++;
         if ({busy, start2_o, start1_o, coin_o} !== 4'b0000)
            $display("FAIL reset cycle %0d: outputs=%b required 0000", i, {busy, start2_o, start1_o, coin_o});
         else n_pass++;
      end
      req_start1 = 1'b0; req_coin = 1'b0; VBLANK = 1'b0;
      cyc();
      RESET = 1'b0;
      run_frame(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, smp, rs, xb);
      n_checks++;
      if (smp !== 4'b0000) $display("FAIL reset idle: outputs=%b required 0000", smp);
      else n_pass++;
   endtask

   task automatic test_p1_pulse();
      period = 100;
      run_auto(1'b1, 1'b0, 0, 1'b0, "p1_pulse");
   endtask

   task automatic test_p2_hold();
      period = 100;
      run_auto(1'b0, 1'b1, 26, 1'b0, "p2_hold");
   endtask

   task automatic test_both();
      period = 100;
      run_auto(1'b1, 1'b1, 2, 1'b0, "both_same_cycle");
   endtask

   task automatic test_manual();
      period = 100;
      run_manual(10, 1'b0, "manual_10");
      run_manual(0, 1'b0, "manual_pulse");
   endtask

   task automatic test_reset_mid();
      logic [3:0] smp, rs;
      bit xb;
      period = 100;
      for (int k = 0; k <= C + G; k++)
         run_frame((k == 0), 1'b0, 1'b0, (k == 0), 1'b0, 1'b0, smp, rs, xb);
      n_checks++;
      if (smp !== 4'b1010) $display("FAIL reset_mid pre: outputs=%b required 1010", smp);
      else n_pass++;
      run_frame(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, smp, rs, xb);
      n_checks++;
      if (rs !== 4'b0000) $display("FAIL reset_mid edge: outputs=%b required 0000", rs);
      else n_pass++;
      n_checks++;
      if (smp !== 4'b0000) $display("FAIL reset_mid after: outputs=%b required 0000", smp);
      else n_pass++;
      run_auto(1'b1, 1'b0, 0, 1'b0, "after_reset");
   endtask

   task automatic test_back_to_back();
      period = 100;
      run_auto(1'b1, 1'b0, 0, 1'b0, "b2b_first");
      run_auto(1'b0, 1'b1, 0, 1'b0, "b2b_second");
   endtask

   task automatic test_random();
      int kind;
      for (int it = 0; it < 8; it++) begin
         period = $urandom_range(60, 100);
         kind = $urandom_range(0, 3);
         case (kind)
            0: run_auto(1'b1, 1'b0, $urandom_range(0, 25), 1'b1, "rand_p1");
            1: run_auto(1'b0, 1'b1, $urandom_range(0, 25), 1'b1, "rand_p2");
            2: run_auto(1'b1, 1'b1, $urandom_range(0, 25), 1'b1, "rand_both");
            default: run_manual($urandom_range(0, 12), 1'b1, "rand_manual");
         endcase
      end
   endtask

   task automatic test_watchdog();
      logic [3:0] smp, rs;
      bit xb;
      logic exp_late;
`ifdef COIN_START_SEQ_WATCHDOG_EN
      exp_late = 1'b0;
`else
      exp_late = 1'b1;
`endif
      period = 100;
      run_frame(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, smp, rs, xb);
      VBLANK = 1'b0;
      for (int i = 1; i <= 700; i++) begin
         cyc();
         if (i == 400) begin
            n_checks++;
            if (coin_o !== 1'b1) $display("FAIL watchdog early: coin_o=%b required 1", coin_o);
            else n_pass++;
         end
         if (i == 700) begin
            n_checks++;
            if (coin_o !== exp_late) $display("FAIL watchdog late: coin_o=%b required %b", coin_o, exp_late);
            else n_pass++;
         end
      end
      for (int k = 0; k < 15; k++)
         run_frame(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, smp, rs, xb);
      n_checks++;
      if (smp !== 4'b0000) $display("FAIL watchdog recover: outputs=%b required 0000", smp);
      else n_pass++;
   endtask

   initial begin
      RESET = 1'b1;
      VBLANK = 1'b0;
      req_start1 = 1'b0;
      req_start2 = 1'b0;
      req_coin = 1'b0;
      test_reset();
      test_p1_pulse();
      test_p2_hold();
      test_both();
      test_manual();
      test_reset_mid();
      test_back_to_back();
      test_random();
      test_watchdog();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
